// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared defaults and sizing helper for the synchronous FIFO slice.
package fifo_sync_ctrl_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AF_LEVEL = 6;
  localparam int DEF_AE_LEVEL = 2;

  // Pointer/count width: one extra bit beyond the index so that
  // full and empty can be told apart (wrap bit / occupancy DEPTH).
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Producer/consumer port bundle of the FIFO.
//
// Handshake: wr_en and rd_en are requests, not valid/ready pairs. A write
// is taken on the clock edge when wr_en is high and there is room (or a
// read frees a slot on the same edge); a read is taken when rd_en is high
// and the FIFO is not empty. Rejected requests are not retried by the FIFO,
// they only raise the sticky overflow/underflow flags. Popped data appears
// on rd_data one cycle after the accepted read, qualified by rd_valid.
interface fifo_sync_ctrl_if
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = ptr_w(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // Producer/consumer side (the bench or upstream logic).
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_ctrl_ptr.sv
// Wrap-bit pointer register with asynchronous active-low clear.
module fifo_sync_ctrl_ptr
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int PW = ptr_w(DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Advance by one on each accepted access; wraps modulo 2*DEPTH naturally.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Synchronous register-file FIFO with occupancy count and status flags.
module fifo_sync_ctrl
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic             clk,
  input  logic             clr,
  fifo_sync_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] AF_L    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             empty;
  logic             full;
  logic             wr_acc;
  logic             rd_acc;

  fifo_sync_ctrl_ptr #(.PW(CW)) u_wr_ptr (
    .clk (clk),
    .clr (clr),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_sync_ctrl_ptr #(.PW(CW)) u_rd_ptr (
    .clk (clk),
    .clr (clr),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Status from the pointers and accept decisions. A write into a full
  // FIFO is still taken when a read frees the slot on the same edge; an
  // empty FIFO never bypasses write data to the read side.
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_acc = bus.rd_en && !empty;
    wr_acc = bus.wr_en && (!full || rd_acc);
  end

  // Next occupancy: +1 on write only, -1 on read only, else unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately not reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  // Registered read port, count and sticky error flags.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr[AW-1:0]];
      end
      if (bus.wr_en && !wr_acc) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.rd_data      = rd_data_q;
    bus.rd_valid     = rd_valid_q;
    bus.full         = full;
    bus.empty        = empty;
    bus.almost_full  = (count_q >= AF_L);
    bus.almost_empty = (count_q <= AE_L);
    bus.count        = count_q;
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl: reset, fill/drain, overflow,
// simultaneous access at full and empty, pointer wrap, async reset.
module tb_fifo_sync_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic clr;

  int n_checks;
  int n_errors;

  logic [WIDTH-1:0] exp_q[$];

  fifo_sync_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_sync_ctrl #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [WIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.rd_en   = 1'b0;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Pop one word and compare it with the head of the expected queue.
  task automatic do_read(input string tag);
    logic [WIDTH-1:0] e;
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, bus.rd_data}, {24'd0, e});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] fill_vals [8];
    n_checks = 0;
    n_errors = 0;
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    clr         = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count",    {28'd0, bus.count},        32'd0);
    check("rst_empty",    {31'd0, bus.empty},        32'd1);
    check("rst_full",     {31'd0, bus.full},         32'd0);
    check("rst_ae",       {31'd0, bus.almost_empty}, 32'd1);
    check("rst_af",       {31'd0, bus.almost_full},  32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid},     32'd0);
    check("rst_rd_data",  {24'd0, bus.rd_data},      32'd0);
    check("rst_ovf",      {31'd0, bus.overflow},     32'd0);
    check("rst_unf",      {31'd0, bus.underflow},    32'd0);

    clr = 1'b1;
    tick();

    // Fill 0x11..0x88, watch count and the level flags
    for (int i = 0; i < 8; i++) begin
      do_write(fill_vals[i]);
      exp_q.push_back(fill_vals[i]);
      check("fill_count", {28'd0, bus.count},        i + 1);
      check("fill_af",    {31'd0, bus.almost_full},  (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("fill_ae",    {31'd0, bus.almost_empty}, (i + 1 <= 2) ? 32'd1 : 32'd0);
    end
    check("fill_full",  {31'd0, bus.full},  32'd1);
    check("fill_empty", {31'd0, bus.empty}, 32'd0);

    // Plain drain in order
    for (int i = 0; i < 8; i++) begin
      do_read("drain1");
      check("drain1_count", {28'd0, bus.count}, 7 - i);
    end
    check("drain1_empty", {31'd0, bus.empty}, 32'd1);
    check("drain1_full",  {31'd0, bus.full},  32'd0);
    tick();
    check("idle_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("idle_rd_hold",  {24'd0, bus.rd_data},  32'h88);

    // Refill, then reject a write while full
    for (int i = 0; i < 8; i++) do_write(fill_vals[i]);
    check("ovf_pre", {31'd0, bus.overflow}, 32'd0);
    do_write(8'hAA);
    check("ovf_flag",  {31'd0, bus.overflow}, 32'd1);
    check("ovf_count", {28'd0, bus.count},    32'd8);
    check("ovf_full",  {31'd0, bus.full},     32'd1);

    // Simultaneous read and write while full
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h5C;
    bus.rd_en   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("fsim_valid", {31'd0, bus.rd_valid}, 32'd1);
    check("fsim_data",  {24'd0, bus.rd_data},  32'h11);
    check("fsim_count", {28'd0, bus.count},    32'd8);
    check("fsim_ovf",   {31'd0, bus.overflow}, 32'd1);

    // Drain: 0x22..0x88 then 0x5C; 0xAA must not appear
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h5C};
    for (int i = 0; i < 8; i++) do_read("drain2");
    check("drain2_empty", {31'd0, bus.empty},     32'd1);
    check("drain2_unf",   {31'd0, bus.underflow}, 32'd0);

    // Simultaneous read and write while empty: write only, no bypass
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h3D;
    bus.rd_en   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("esim_unf",   {31'd0, bus.underflow}, 32'd1);
    check("esim_valid", {31'd0, bus.rd_valid},  32'd0);
    check("esim_count", {28'd0, bus.count},     32'd1);
    exp_q.push_back(8'h3D);
    do_read("esim_read");
    check("esim_empty", {31'd0, bus.empty}, 32'd1);

    // Wrap: 20 write/read pairs
    for (int i = 0; i < 20; i++) begin
      do_write(8'(i));
      exp_q.push_back(8'(i));
      check("wrap_count_w", {28'd0, bus.count}, 32'd1);
      do_read("wrap");
      check("wrap_count_r", {28'd0, bus.count}, 32'd0);
    end

    // Async reset mid-stream with count 5 and a word just popped
    for (int i = 0; i < 6; i++) do_write(8'hC0 + 8'(i));
    exp_q.push_back(8'hC0);
    do_read("pre_rst");
    check("pre_rst_count", {28'd0, bus.count}, 32'd5);
    #1;
    clr = 1'b0;
    #1;
    check("arst_count",    {28'd0, bus.count},     32'd0);
    check("arst_empty",    {31'd0, bus.empty},     32'd1);
    check("arst_rd_valid", {31'd0, bus.rd_valid},  32'd0);
    check("arst_ovf",      {31'd0, bus.overflow},  32'd0);
    check("arst_unf",      {31'd0, bus.underflow}, 32'd0);
    check("arst_rd_data",  {24'd0, bus.rd_data},   32'd0);
    #1;
    clr = 1'b1;

    // After reset the FIFO behaves as from empty
    do_write(8'h77);
    check("post_count", {28'd0, bus.count}, 32'd1);
    exp_q.push_back(8'h77);
    do_read("post_read");
    check("post_empty", {31'd0, bus.empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
